stream_demux1ton: RTL and testbench
===================================

Name: stream_demux1toN

Overview:
- Registered 1-to-NOUT demultiplexer for valid/ready packet streams; the inverse of the team's 2-to-1 / N-to-1 mux blocks.
- Routes each input packet, whole and unsplit, to the output channel named by sel.
- sel is captured on the first beat and locked until the last beat.
- Sits between a single producer and NOUT consumers (e.g. per-lane processing units).

Parameters:
- W, 8, data width in bits.
- NOUT, 4, number of output channels; 2 <= NOUT <= 2^SW.
- SW, 2, select width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  W  input beat payload.
- in_last  in  1  marks the final beat of a packet.
- sel  in  SW  destination channel; sampled only on the first beat of a packet.
- out_valid  out  NOUT  one-hot-or-zero per-channel valid.
- out_ready  in  NOUT  per-channel ready.
- out_data  out  W  shared payload bus, valid for the channel whose out_valid is set.
- out_last  out  1  shared last flag.
- busy  out  1  high while a packet is in progress (state PKT) or buf_valid is set.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0, in_ready = 1.
  - Internal registers: buf_valid = 0, buf_ch = 0, lock_ch = 0, state = IDLE.
- Output stage: a single shared output register (buf_data, buf_last, buf_ch, buf_valid).
  - out_valid[i] = buf_valid && (buf_ch == i).
  - out_data = buf_data; out_last = buf_last (both registered).
- Drain condition: drain = buf_valid && out_ready[buf_ch].
- Ready: in_ready = !buf_valid || drain (combinational). Allows full throughput of 1 beat/cycle with no bubble.
- Latency: an accepted beat appears on its out_valid bit exactly 1 cycle after acceptance.
- State machine:
  - IDLE: on accept, ch = clamp(sel).
    - If !in_last, lock_ch <= ch and state -> PKT.
    - If in_last (1-beat packet), stay in IDLE.
  - PKT: each accepted beat uses lock_ch; sel is ignored. On an accepted beat with in_last, state -> IDLE.
- Clamp: sel >= NOUT maps to channel NOUT-1 (default build).
- Simultaneous events: drain and accept in the same cycle give buf <= new beat, buf_valid stays 1.
- Drain without accept: buf_valid <= 0.
- Hold rule: out_valid/out_data/out_last hold stable while the selected out_ready = 0.
- Backpressure isolation: out_ready of non-selected channels has no effect.
- Reset mid-packet: immediately returns to the reset values; the partial packet is discarded. The next beat is treated as a first beat.
- in_valid low in PKT: state is held, no timeout.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_EN.
- Defined:
  - A first beat with sel >= NOUT marks the packet "drop". All its beats are accepted (in_ready per the normal rule) but never loaded into buf, and no out_valid is raised.
  - Added port drop_cnt, out, 8 bits. Increments by 1 on acceptance of the first beat of a dropped packet. Saturates at 255. Reset value 0.
- Undefined: clamp behaviour as above; no drop_cnt port.

Test Plan:
- Single beats with sel = 0,1,2,3, data 0x11,0x22,0x33,0x44, last = 1, all out_ready = 1 -> each appears 1 cycle later on out_valid = 0001,0010,0100,1000 with matching data; in_ready stays 1.
- 3-beat packet: sel = 2 on beat 0, sel changed to 0 on beats 1–2, data 0xA0..0xA2 -> all three beats on channel 2, out_last on 0xA2 only.
- Backpressure: out_ready[1] = 0 for 3 cycles while a beat is buffered for channel 1; out_ready[0] = 1 -> in_ready = 0, out_data held at the same value, out_valid = 0010 steady. Release -> back-to-back stream resumes with no lost beat.
- Reset asserted after beat 2 of a 4-beat packet to channel 3 -> outputs are zero asynchronously. After release, a new beat with sel = 1 is routed to channel 1.
- NOUT = 3, sel = 3 (out of range), 2-beat packet:
  - Default build: delivered on channel 2.
  - With STREAM_DEMUX_DROP_EN: both beats accepted, no out_valid, drop_cnt 0 -> 1.
- Continuous stream of 16 single-beat packets, all ready = 1 -> 16 outputs in 16 consecutive cycles, busy = 1 throughout and 0 one cycle after the last drain.

Source files
------------

// File: rtl/stream_demux1ton.sv
// Registered 1-to-NOUT packet demux; sel locked from first to last beat.
// Define STREAM_DEMUX_DROP_EN to drop out-of-range packets instead of clamping.
module stream_demux1ton #(
    parameter int W    = 8,
    parameter int NOUT = 4,
    parameter int SW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    input  logic [SW-1:0]   sel,
    output logic [NOUT-1:0] out_valid,
    input  logic [NOUT-1:0] out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
`ifdef STREAM_DEMUX_DROP_EN
    output logic [7:0]      drop_cnt,
`endif
    output logic            busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PKT  = 1'b1;

    localparam logic [SW:0]   NOUT_W  = (SW+1)'(NOUT);
    localparam logic [SW-1:0] LAST_CH = SW'(NOUT - 1);

    logic [0:0]    state;
    logic [SW-1:0] lock_ch;
    logic [W-1:0]  buf_data;
    logic          buf_last;
    logic [SW-1:0] buf_ch;
    logic          buf_valid;

    logic          sel_oor;
    logic [SW-1:0] ch_sel;
    logic [SW-1:0] cur_ch;
    logic          cur_drop;
    logic          ch_rdy;
    logic          drain;
    logic          accept;
    logic          load;

    assign sel_oor = {1'b0, sel} >= NOUT_W;
    assign ch_sel  = sel_oor ? LAST_CH : sel;
    assign cur_ch  = (state == PKT) ? lock_ch : ch_sel;

`ifdef STREAM_DEMUX_DROP_EN
    logic lock_drop;
    assign cur_drop = (state == PKT) ? lock_drop : sel_oor;
`else
    assign cur_drop = 1'b0;
`endif

    always_comb begin
        ch_rdy = 1'b0;
        for (int i = 0; i < NOUT; i++) begin
            if (buf_ch == SW'(i)) ch_rdy = out_ready[i];
        end
    end

    assign drain    = buf_valid && ch_rdy;
    assign in_ready = !buf_valid || drain;
    assign accept   = in_valid && in_ready;
    assign load     = accept && !cur_drop;

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < NOUT; i++) begin
            out_valid[i] = buf_valid && (buf_ch == SW'(i));
        end
    end

    assign out_data = buf_data;
    assign out_last = buf_last;
    assign busy     = (state == PKT) || buf_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_last  <= 1'b0;
            buf_ch    <= '0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_data  <= in_data;
            buf_last  <= in_last;
            buf_ch    <= cur_ch;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                if (!in_last) begin
                    lock_ch <= ch_sel;
                    state   <= PKT;
                end
            end else if (in_last) begin
                state <= IDLE;
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_EN
    // Drop decision is taken on the first beat and held for the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_drop <= 1'b0;
            drop_cnt  <= 8'd0;
        end else if (accept && state == IDLE) begin
            lock_drop <= sel_oor;
            if (sel_oor && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux1ton.sv
// Directed table + hand sequences for stream_demux1ton (NOUT=4 and NOUT=3).
module tb_stream_demux1ton;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'hF;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    logic       v3 = 1'b0;
    logic       rdy3;
    logic [7:0] d3 = '0;
    logic       l3 = 1'b0;
    logic [1:0] s3 = '0;
    logic [2:0] ov3;
    logic [7:0] od3;
    logic       ol3;
    logic       busy3;

`ifdef STREAM_DEMUX_DROP_EN
    logic [7:0] dcnt;
    logic [7:0] dcnt3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_demux1ton #(.W(8), .NOUT(4), .SW(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
`ifdef STREAM_DEMUX_DROP_EN
        .drop_cnt(dcnt),
`endif
        .busy(busy)
    );

    stream_demux1ton #(.W(8), .NOUT(3), .SW(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v3), .in_ready(rdy3),
        .in_data(d3), .in_last(l3), .sel(s3),
        .out_valid(ov3), .out_ready(3'b111),
        .out_data(od3), .out_last(ol3),
`ifdef STREAM_DEMUX_DROP_EN
        .drop_cnt(dcnt3),
`endif
        .busy(busy3)
    );

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic       l;
        logic [3:0] ordy;
        logic       e_rdy;
        logic [3:0] e_ov;
        logic [7:0] e_d;
        logic       e_l;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic l,
                       input logic [3:0] ordy, input logic e_rdy,
                       input logic [3:0] e_ov, input logic [7:0] e_d,
                       input logic e_l, input logic e_busy);
        vec_t t;
        t.v = v; t.sel = s; t.d = d; t.l = l; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_d = e_d;
        t.e_l = e_l; t.e_busy = e_busy;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic l);
        in_valid = v; sel = s; in_data = d; in_last = l;
    endtask

    initial begin
        // single beats to every channel
        add(1, 0, 8'h11, 1, 4'hF, 1, 4'b0001, 8'h11, 1, 1);
        add(1, 1, 8'h22, 1, 4'hF, 1, 4'b0010, 8'h22, 1, 1);
        add(1, 2, 8'h33, 1, 4'hF, 1, 4'b0100, 8'h33, 1, 1);
        add(1, 3, 8'h44, 1, 4'hF, 1, 4'b1000, 8'h44, 1, 1);
        // 3-beat packet, sel changes mid-packet
        add(1, 2, 8'hA0, 0, 4'hF, 1, 4'b0100, 8'hA0, 0, 1);
        add(1, 0, 8'hA1, 0, 4'hF, 1, 4'b0100, 8'hA1, 0, 1);
        add(1, 0, 8'hA2, 1, 4'hF, 1, 4'b0100, 8'hA2, 1, 1);
        // backpressure on channel 1
        add(1, 1, 8'h55, 1, 4'hF, 1, 4'b0010, 8'h55, 1, 1);
        add(1, 0, 8'h66, 1, 4'b1101, 0, 4'b0010, 8'h55, 1, 1);
        add(1, 0, 8'h66, 1, 4'b1101, 0, 4'b0010, 8'h55, 1, 1);
        add(1, 0, 8'h66, 1, 4'b1101, 0, 4'b0010, 8'h55, 1, 1);
        add(1, 0, 8'h66, 1, 4'hF, 1, 4'b0001, 8'h66, 1, 1);
        add(0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 8'h66, 1, 0);
        // in_valid gap inside a packet
        add(1, 3, 8'hD0, 0, 4'hF, 1, 4'b1000, 8'hD0, 0, 1);
        add(0, 1, 8'h00, 0, 4'hF, 1, 4'b0000, 8'hD0, 0, 1);
        add(1, 0, 8'hD1, 1, 4'hF, 1, 4'b1000, 8'hD1, 1, 1);
        add(0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 8'hD1, 1, 0);
        // only the selected ready matters
        add(1, 1, 8'hE0, 1, 4'hF, 1, 4'b0010, 8'hE0, 1, 1);
        add(1, 1, 8'hE1, 1, 4'b0010, 1, 4'b0010, 8'hE1, 1, 1);
        add(0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 8'hE1, 1, 0);

        #2;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", 32'(out_data), 0);
        chk("rst_ol", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy", 32'(in_ready), 1);
        chk("rst_ov3", 32'(ov3), 0);
`ifdef STREAM_DEMUX_DROP_EN
        chk("rst_dcnt3", 32'(dcnt3), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].l);
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            @(negedge clk);
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_od", i), 32'(out_data), 32'(tbl[i].e_d));
            chk($sformatf("v%0d_ol", i), 32'(out_last), 32'(tbl[i].e_l));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end

        // reset in the middle of a 4-beat packet to channel 3
        out_ready = 4'hF;
        drive(1, 3, 8'hC0, 0);
        @(negedge clk);
        drive(1, 0, 8'hC1, 0);
        @(negedge clk);
        drive(1, 1, 8'hC2, 0);
        @(negedge clk);
        chk("mid_ov", 32'(out_valid), 32'h8);
        chk("mid_od", 32'(out_data), 32'hC2);
        drive(0, 0, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(out_valid), 0);
        chk("arst_od", 32'(out_data), 0);
        chk("arst_ol", 32'(out_last), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rdy", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 8'h77, 1);
        @(negedge clk);
        chk("post_ov", 32'(out_valid), 32'h2);
        chk("post_od", 32'(out_data), 32'h77);
        drive(0, 0, 8'h00, 0);
        @(negedge clk);
        chk("post_busy", 32'(busy), 0);

        // out-of-range sel on NOUT=3
        v3 = 1'b1; s3 = 2'd3; d3 = 8'hB0; l3 = 1'b0;
        #1;
        chk("n3_rdy0", 32'(rdy3), 1);
        @(negedge clk);
`ifdef STREAM_DEMUX_DROP_EN
        chk("n3_ov0", 32'(ov3), 0);
        chk("n3_dcnt", 32'(dcnt3), 1);
`else
        chk("n3_ov0", 32'(ov3), 32'h4);
        chk("n3_od0", 32'(od3), 32'hB0);
`endif
        s3 = 2'd0; d3 = 8'hB1; l3 = 1'b1;
        #1;
        chk("n3_rdy1", 32'(rdy3), 1);
        @(negedge clk);
`ifdef STREAM_DEMUX_DROP_EN
        chk("n3_ov1", 32'(ov3), 0);
        chk("n3_dcnt1", 32'(dcnt3), 1);
`else
        chk("n3_ov1", 32'(ov3), 32'h4);
        chk("n3_od1", 32'(od3), 32'hB1);
        chk("n3_ol1", 32'(ol3), 1);
`endif
        v3 = 1'b0;
        @(negedge clk);
        chk("n3_busy", 32'(busy3), 0);

        // 16 back-to-back single-beat packets
        out_ready = 4'hF;
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'(i), 8'(8'h80 + i), 1);
            #1;
            chk($sformatf("s%0d_rdy", i), 32'(in_ready), 1);
            @(negedge clk);
            chk($sformatf("s%0d_ov", i), 32'(out_valid), 32'(1) << (i % 4));
            chk($sformatf("s%0d_od", i), 32'(out_data), 32'h80 + 32'(i));
            chk($sformatf("s%0d_busy", i), 32'(busy), 1);
        end
        drive(0, 0, 8'h00, 0);
        @(negedge clk);
        chk("s_end_ov", 32'(out_valid), 0);
        chk("s_end_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
